// File: rtl/spi_ram_arbiter.sv
// Two SPI command channels sharing one single-port 8-bit RAM through a round-robin arbiter.
// Optional: define ADDR_AUTO_INC_EN to post-increment wr_addr/rd_addr on each accepted write/read.
module spi_ram_arbiter #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           rx_data_0,
  input  logic                 rx_valid_0,
  output logic [7:0]           tx_data_0,
  output logic                 tx_valid_0,
  output logic                 ovf_0,
  input  logic [9:0]           rx_data_1,
  input  logic                 rx_valid_1,
  output logic [7:0]           tx_data_1,
  output logic                 tx_valid_1,
  output logic                 ovf_1,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [7:0]           ram_wdata,
  input  logic [7:0]           ram_rdata
);

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RDWAIT = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OP_LD_WR = 2'b00,
    OP_WRITE = 2'b01,
    OP_LD_RD = 2'b10,
    OP_READ  = 2'b11
  } opcode_t;

  typedef struct packed {
    logic                 we;
    logic [ADDR_SIZE-1:0] addr;
    logic [7:0]           data;
  } ram_op_t;

  // Payload is 8 bits; zero-extend or truncate to the RAM address width.
  function automatic logic [ADDR_SIZE-1:0] to_addr(input logic [7:0] payload);
    logic [ADDR_SIZE+7:0] ext;
    ext = {{ADDR_SIZE{1'b0}}, payload};
    return ext[ADDR_SIZE-1:0];
  endfunction

`ifdef ADDR_AUTO_INC_EN
  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
    return (a == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : a + ADDR_SIZE'(1);
  endfunction
`endif

  logic [9:0]           rx_data [2];
  logic [1:0]           rx_valid;
  logic [ADDR_SIZE-1:0] wr_addr [2];
  logic [ADDR_SIZE-1:0] rd_addr [2];
  ram_op_t              pend    [2];
  logic [1:0]           pend_v;
  logic [1:0]           ovf;
  logic [7:0]           tx_data [2];
  logic [1:0]           tx_valid;

  arb_state_t state, state_nxt;
  logic [1:0] grant;
  logic       grant_ch;
  logic       rr_favour_1;
  logic       owner;

  assign rx_data[0] = rx_data_0;
  assign rx_data[1] = rx_data_1;
  assign rx_valid   = {rx_valid_1, rx_valid_0};

  // Grant is only issued from ARB_IDLE; with both pending, the channel not served last wins.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_nxt = state;
    grant     = '0;
    unique case (state)
      ARB_IDLE: begin
        if (pend_v == 2'b11) grant[rr_favour_1] = 1'b1;
        else                 grant = pend_v;
        if (pend_v != 2'b00) state_nxt = ARB_ACCESS;
      end
      ARB_ACCESS: state_nxt = ram_we ? ARB_IDLE : ARB_RDWAIT;
      ARB_RDWAIT: state_nxt = ARB_IDLE;
      default:    state_nxt = ARB_IDLE;
    endcase
  end

  assign grant_ch = grant[1];

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with <= only; a blocking write would race readers on the same edge.
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  // Per-channel command decode. A grant on the same edge frees the slot for a new command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        wr_addr[c] <= '0;
        rd_addr[c] <= '0;
        // NOTE: the pending slots are plain registers, not a RAM array, so they reset with the rest.
        pend[c]    <= '0;
      end
      pend_v <= '0;
      ovf    <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (grant[c]) pend_v[c] <= 1'b0;
        if (rx_valid[c]) begin
          unique case (opcode_t'(rx_data[c][9:8]))
            OP_LD_WR: wr_addr[c] <= to_addr(rx_data[c][7:0]);
            OP_LD_RD: rd_addr[c] <= to_addr(rx_data[c][7:0]);
            OP_WRITE: begin
              if (!pend_v[c] || grant[c]) begin
                pend[c]   <= '{we: 1'b1, addr: wr_addr[c], data: rx_data[c][7:0]};
                pend_v[c] <= 1'b1;
`ifdef ADDR_AUTO_INC_EN
                wr_addr[c] <= next_addr(wr_addr[c]);
`endif
              end else begin
                ovf[c] <= 1'b1;
              end
            end
            OP_READ: begin
              if (!pend_v[c] || grant[c]) begin
                pend[c]   <= '{we: 1'b0, addr: rd_addr[c], data: 8'h00};
                pend_v[c] <= 1'b1;
`ifdef ADDR_AUTO_INC_EN
                rd_addr[c] <= next_addr(rd_addr[c]);
`endif
              end else begin
                ovf[c] <= 1'b1;
              end
            end
          endcase
        end
      end
    end
  end

  // RAM port drive and read-data return to the owning channel only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      owner       <= 1'b0;
      rr_favour_1 <= 1'b0;
      tx_valid    <= '0;
      tx_data[0]  <= '0;
      tx_data[1]  <= '0;
    end else begin
      ram_en   <= |grant;
      tx_valid <= '0;
      if (|grant) begin
        ram_we      <= pend[grant_ch].we;
        ram_addr    <= pend[grant_ch].addr;
        ram_wdata   <= pend[grant_ch].data;
        owner       <= grant_ch;
        rr_favour_1 <= ~grant_ch;
      end
      if (state == ARB_RDWAIT) begin
        tx_data[owner]  <= ram_rdata;
        tx_valid[owner] <= 1'b1;
      end
    end
  end

  assign tx_data_0  = tx_data[0];
  assign tx_data_1  = tx_data[1];
  assign tx_valid_0 = tx_valid[0];
  assign tx_valid_1 = tx_valid[1];
  assign ovf_0      = ovf[0];
  assign ovf_1      = ovf[1];

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter with a behavioural 256x8 synchronous RAM and event logs.
module tb_spi_ram_arbiter;

  localparam bit AUTO_INC =
`ifdef ADDR_AUTO_INC_EN
    1'b1;
`else
    1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [9:0] rx_data_0, rx_data_1;
  logic       rx_valid_0, rx_valid_1;
  logic [7:0] tx_data_0, tx_data_1;
  logic       tx_valid_0, tx_valid_1;
  logic       ovf_0, ovf_1;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;

  spi_ram_arbiter #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data_0(rx_data_0), .rx_valid_0(rx_valid_0),
    .tx_data_0(tx_data_0), .tx_valid_0(tx_valid_0), .ovf_0(ovf_0),
    .rx_data_1(rx_data_1), .rx_valid_1(rx_valid_1),
    .tx_data_1(tx_data_1), .tx_valid_1(tx_valid_1), .ovf_1(ovf_1),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: read data appears the cycle after the ram_en read cycle.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  // Logs of RAM accesses {we, addr, wdata} and per-channel read returns.
  logic [16:0] ops [$];
  logic [7:0]  tx0 [$];
  logic [7:0]  tx1 [$];
  always @(negedge clk) begin
    if (ram_en)     ops.push_back({ram_we, ram_addr, ram_wdata});
    if (tx_valid_0) tx0.push_back(tx_data_0);
    if (tx_valid_1) tx1.push_back(tx_data_1);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] cmd(input logic [1:0] op, input logic [7:0] payload);
    return {op, payload};
  endfunction

  function automatic logic [16:0] op_at(input int i);
    if (i < ops.size()) return ops[i];
    return 17'h1ffff;
  endfunction

  function automatic logic [63:0] all_outs();
    return {26'b0, ram_en, ram_we, ram_addr, ram_wdata, tx_valid_0, tx_data_0,
            tx_valid_1, tx_data_1, ovf_0, ovf_1};
  endfunction

  // Called at a negedge; commands are sampled on the following posedge.
  task automatic drive(input logic v0, input logic [9:0] d0, input logic v1, input logic [9:0] d1);
    rx_valid_0 = v0; rx_data_0 = d0;
    rx_valid_1 = v1; rx_data_1 = d1;
    @(negedge clk);
    rx_valid_0 = 1'b0; rx_data_0 = '0;
    rx_valid_1 = 1'b0; rx_data_1 = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    check("reset_outputs", all_outs(), 64'h0);
    rst_n = 1'b1;
    idle(1);
  endtask

  int base, b0, b1, lat_en, lat_tx;

  initial begin
    rst_n = 1'b0;
    rx_valid_0 = 1'b0; rx_data_0 = '0;
    rx_valid_1 = 1'b0; rx_data_1 = '0;
    idle(3);
    check("por_outputs", all_outs(), 64'h0);
    rst_n = 1'b1;
    idle(2);

    // Write 0xA5 @0x10 then read it back on ch0; check ram_en and tx latency.
    base = ops.size();
    drive(1'b1, cmd(2'b00, 8'h10), 1'b0, '0);
    drive(1'b1, cmd(2'b01, 8'hA5), 1'b0, '0);
    drive(1'b1, cmd(2'b10, 8'h10), 1'b0, '0);
    drive(1'b1, cmd(2'b11, 8'h00), 1'b0, '0);
    lat_en = -1; lat_tx = -1;
    for (int n = 0; n < 10; n++) begin
      if (ram_en && !ram_we && lat_en < 0) lat_en = n;
      if (tx_valid_0) begin
        lat_tx = n;
        break;
      end
      @(negedge clk);
    end
    check("t1_ram_en_latency", lat_en, 1);
    check("t1_tx_latency", lat_tx, 3);
    check("t1_tx_data", tx_data_0, 8'hA5);
    @(negedge clk);
    check("t1_tx_pulse", tx_valid_0, 1'b0);
    check("t1_write_op", op_at(base), {1'b1, 8'h10, 8'hA5});
    check("t1_read_op", op_at(base + 1) >> 8, {1'b0, 8'h10});
    check("t1_no_ch1_tx", tx1.size(), 0);

    // Simultaneous writes to 0x20 from reset: ch0 first, ch1 second; ch1 readback.
    do_reset();
    base = ops.size(); b0 = tx0.size();
    drive(1'b1, cmd(2'b00, 8'h20), 1'b1, cmd(2'b00, 8'h20));
    drive(1'b1, cmd(2'b01, 8'h3C), 1'b1, cmd(2'b01, 8'hC3));
    idle(6);
    check("t2_first_grant", op_at(base), {1'b1, 8'h20, 8'h3C});
    check("t2_second_grant", op_at(base + 1), {1'b1, 8'h20, 8'hC3});
    drive(1'b0, '0, 1'b1, cmd(2'b10, 8'h20));
    drive(1'b0, '0, 1'b1, cmd(2'b11, 8'h00));
    idle(6);
    check("t2_ch1_tx_count", tx1.size(), 1);
    check("t2_ch1_readback", (tx1.size() > 0) ? tx1[tx1.size() - 1] : 8'hxx, 8'hC3);
    check("t2_no_ch0_tx", tx0.size(), b0);

    // Both channels reading back-to-back: strict alternation, data to the right channel.
    base = ops.size(); b0 = tx0.size(); b1 = tx1.size();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, cmd(2'b10, 8'h10), 1'b1, cmd(2'b10, 8'h20));
      drive(1'b1, cmd(2'b11, 8'h00), 1'b1, cmd(2'b11, 8'h00));
      idle(4);
    end
    idle(6);
    check("t3_op_count", ops.size() - base, 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("t3_grant_%0d", i), op_at(base + i) >> 8, {1'b0, (i % 2 == 0) ? 8'h10 : 8'h20});
    check("t3_ch0_tx_count", tx0.size() - b0, 3);
    check("t3_ch1_tx_count", tx1.size() - b1, 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_ch0_data_%0d", i), (b0 + i < tx0.size()) ? tx0[b0 + i] : 8'hxx, 8'hA5);
      check($sformatf("t3_ch1_data_%0d", i), (b1 + i < tx1.size()) ? tx1[b1 + i] : 8'hxx, 8'hC3);
    end
    check("t3_no_ovf", {ovf_0, ovf_1}, 2'b00);

    // ch1 issues two writes while ch0 holds the RAM: second is dropped, ovf_1 sets.
    drive(1'b1, cmd(2'b10, 8'h10), 1'b1, cmd(2'b00, 8'h30));
    base = ops.size();
    drive(1'b1, cmd(2'b11, 8'h00), 1'b0, '0);
    drive(1'b0, '0, 1'b1, cmd(2'b01, 8'h77));
    drive(1'b0, '0, 1'b1, cmd(2'b01, 8'h88));
    idle(8);
    check("t4_ovf", {ovf_0, ovf_1}, 2'b01);
    check("t4_op_count", ops.size() - base, 2);
    check("t4_ch0_read", op_at(base) >> 8, {1'b0, 8'h10});
    check("t4_ch1_write", op_at(base + 1), {1'b1, 8'h30, 8'h77});
    check("t4_mem", mem[8'h30], 8'h77);

    // Reset asserted while the arbiter waits for read data; ch1 write is still queued.
    b0 = tx0.size();
    drive(1'b1, cmd(2'b11, 8'h00), 1'b0, '0);
    drive(1'b0, '0, 1'b1, cmd(2'b01, 8'h99));
    @(negedge clk);
    base = ops.size();
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_outputs_in_reset", all_outs(), 64'h0);
    rst_n = 1'b1;
    idle(6);
    check("t5_no_tx", tx0.size(), b0);
    check("t5_pending_dropped", ops.size(), base);
    drive(1'b0, '0, 1'b1, cmd(2'b01, 8'h5A));
    idle(3);
    drive(1'b1, cmd(2'b11, 8'h00), 1'b0, '0);
    idle(5);
    check("t5_write_addr0", op_at(base), {1'b1, 8'h00, 8'h5A});
    check("t5_read_addr0", op_at(base + 1) >> 8, {1'b0, 8'h00});
    check("t5_tx_after_reset", (tx0.size() > b0) ? tx0[tx0.size() - 1] : 8'hxx, 8'h5A);

    // Back-to-back writes at 0xFF: grant on the same edge frees the slot; wrap with auto-inc.
    base = ops.size();
    drive(1'b1, cmd(2'b00, 8'hFF), 1'b0, '0);
    drive(1'b1, cmd(2'b01, 8'h11), 1'b0, '0);
    drive(1'b1, cmd(2'b01, 8'h22), 1'b0, '0);
    idle(6);
    check("t6_no_ovf", ovf_0, 1'b0);
    check("t6_first_write", op_at(base), {1'b1, 8'hFF, 8'h11});
    check("t6_second_write", op_at(base + 1), {1'b1, AUTO_INC ? 8'h00 : 8'hFF, 8'h22});
    check("t6_mem", AUTO_INC ? {mem[8'hFF], mem[8'h00]} : {8'h00, mem[8'hFF]},
          AUTO_INC ? 16'h1122 : 16'h0022);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
